// File: rtl/prog_loader_if.sv
// Instruction-store write port driven by the boot loader.
interface prog_loader_if;
  logic        mem_ce;
  logic        mem_wre;
  logic [10:0] mem_ad;
  logic [15:0] mem_din;

  modport master (output mem_ce, mem_wre, mem_ad, mem_din);
  modport slave  (input  mem_ce, mem_wre, mem_ad, mem_din);
endinterface

// File: rtl/prog_loader.sv
// UART boot loader: receives a framed, checksummed program image and writes
// 16-bit words into the instruction store while holding `loading` high.
module prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned TIMEOUT_CLKS = 1048576
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_rx,
  prog_loader_if.master   mem,
  output logic            loading,
  output logic            done,
  output logic            err
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_LO, DATA_HI, CSUM} state_t;

  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_bit, rx_bit_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic            rx_valid, rx_valid_n, rx_ferr, rx_ferr_n;

  state_t          state, state_n;
  logic [7:0]      len_hi, len_hi_n, lo_byte, lo_byte_n, csum, csum_n;
  logic [11:0]     remain, remain_n;
  logic [10:0]     addr, addr_n, ad, ad_n;
  logic [15:0]     din, din_n, len;
  logic [TW-1:0]   tmo, tmo_n;
  logic            wre, wre_n, loading_n, done_n, err_n, abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_HUNT;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_valid <= rx_valid_n;
      rx_ferr  <= rx_ferr_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_valid_n = 1'b0;
    rx_ferr_n  = 1'b0;
    case (rx_state)
      RX_HUNT: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt == HALF_LAST) begin
        // A start bit that is high again at mid-bit was a glitch.
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_sync ? RX_HUNT : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_sync, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 1'b1;
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_state_n = RX_HUNT;
        rx_valid_n = rx_sync;
        rx_ferr_n  = !rx_sync;
      end
      default: rx_state_n = RX_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      len_hi  <= '0;
      lo_byte <= '0;
      csum    <= '0;
      remain  <= '0;
      addr    <= '0;
      ad      <= '0;
      din     <= '0;
      tmo     <= '0;
      wre     <= 1'b0;
      loading <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      len_hi  <= len_hi_n;
      lo_byte <= lo_byte_n;
      csum    <= csum_n;
      remain  <= remain_n;
      addr    <= addr_n;
      ad      <= ad_n;
      din     <= din_n;
      tmo     <= tmo_n;
      wre     <= wre_n;
      loading <= loading_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  assign len = {len_hi, rx_shift};

  always_comb begin
    state_n   = state;
    len_hi_n  = len_hi;
    lo_byte_n = lo_byte;
    csum_n    = csum;
    remain_n  = remain;
    addr_n    = addr;
    ad_n      = ad;
    din_n     = din;
    wre_n     = 1'b0;
    loading_n = loading;
    done_n    = done;
    err_n     = err;
    tmo_n     = (state == IDLE || rx_valid) ? '0 : tmo + 1'b1;
    abort     = (state != IDLE) && (rx_ferr || (!rx_valid && tmo == TMO_LAST));
    case (state)
      IDLE: if (rx_valid && rx_shift == 8'hA5) begin
        done_n    = 1'b0;
        err_n     = 1'b0;
        addr_n    = '0;
        csum_n    = '0;
        loading_n = 1'b1;
        state_n   = LEN_HI;
      end
      LEN_HI: if (rx_valid) begin
        len_hi_n = rx_shift;
        state_n  = LEN_LO;
      end
      LEN_LO: if (rx_valid) begin
        if (len == 16'd0)          state_n = CSUM;
        else if (len > 16'd2048)   abort   = 1'b1;
        else begin
          remain_n = len[11:0];
          state_n  = DATA_LO;
        end
      end
      DATA_LO: if (rx_valid) begin
        lo_byte_n = rx_shift;
        csum_n    = csum + rx_shift;
        state_n   = DATA_HI;
      end
      DATA_HI: if (rx_valid) begin
        csum_n   = csum + rx_shift;
        wre_n    = 1'b1;
        ad_n     = addr;
        din_n    = {rx_shift, lo_byte};
        addr_n   = addr + 1'b1;
        remain_n = remain - 1'b1;
        state_n  = (remain == 12'd1) ? CSUM : DATA_LO;
      end
      CSUM: if (rx_valid) begin
        if (rx_shift == csum) done_n = 1'b1;
        else                  err_n  = 1'b1;
        loading_n = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n   = IDLE;
      err_n     = 1'b1;
      loading_n = 1'b0;
      wre_n     = 1'b0;
    end
  end

  assign mem.mem_ce  = wre;
  assign mem.mem_wre = wre;
  assign mem.mem_ad  = ad;
  assign mem.mem_din = din;
endmodule

// File: tb/tb_prog_loader.sv
// Directed frames into prog_loader; a scoreboard queue holds the expected writes.
module tb_prog_loader;
  localparam int unsigned CPB = 16;
  localparam int unsigned TMO = 3000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_rx = 1'b1;
  logic loading, done, err;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [26:0] sb[$];
  logic prev_wre = 1'b0;

  prog_loader_if mem_bus ();

  prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .mem(mem_bus),
    .loading(loading), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (mem_bus.mem_wre || mem_bus.mem_ce) begin
      check("ce_eq_wre", 32'(mem_bus.mem_ce), 32'(mem_bus.mem_wre));
      check("no_b2b_write", 32'(prev_wre), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got ad=%h din=%h expected none", mem_bus.mem_ad, mem_bus.mem_din);
      end else begin
        logic [26:0] e;
        e = sb.pop_front();
        check("wr_addr", 32'(mem_bus.mem_ad), 32'(e[26:16]));
        check("wr_data", 32'(mem_bus.mem_din), 32'(e[15:0]));
      end
    end
    prev_wre = mem_bus.mem_wre;
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic expect_st(input string name, input logic l, input logic d, input logic e);
    @(negedge clk);
    check({name, "_loading"}, 32'(loading), 32'(l));
    check({name, "_done"}, 32'(done), 32'(d));
    check({name, "_err"}, 32'(err), 32'(e));
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wre", 32'(mem_bus.mem_wre), 32'd0);
    check("rst_ce", 32'(mem_bus.mem_ce), 32'd0);
    check("rst_ad", 32'(mem_bus.mem_ad), 32'd0);
    check("rst_din", 32'(mem_bus.mem_din), 32'd0);
    expect_st("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (4 * CPB) @(posedge clk);

    // Good frame: checksum 0x34+0x12+0x78+0x56 = 0x114 -> 0x14
    sb.push_back({11'd0, 16'h1234});
    sb.push_back({11'd1, 16'h5678});
    send(8'hA5);
    expect_st("sync", 1'b1, 1'b0, 1'b0);
    send(8'h00); send(8'h02); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    send(8'h14);
    expect_st("good", 1'b0, 1'b1, 1'b0);

    sb.push_back({11'd0, 16'h1234});
    sb.push_back({11'd1, 16'h5678});
    send(8'hA5); send(8'h00); send(8'h02); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    send(8'hF5);
    expect_st("badsum", 1'b0, 1'b0, 1'b1);

    send(8'hA5); send(8'h08); send(8'h01);
    expect_st("toolong", 1'b0, 1'b0, 1'b1);
    // 0xCD+0xAB = 0x178 -> 0x78
    sb.push_back({11'd0, 16'hABCD});
    send(8'hA5); send(8'h00); send(8'h01); send(8'hCD); send(8'hAB); send(8'h78);
    expect_st("after_long", 1'b0, 1'b1, 1'b0);

    send(8'h00);
    expect_st("junk00", 1'b0, 1'b1, 1'b0);
    send(8'hFF);
    expect_st("junkff", 1'b0, 1'b1, 1'b0);
    send(8'h13);
    expect_st("junk13", 1'b0, 1'b1, 1'b0);
    sb.push_back({11'd0, 16'h2211});
    send(8'hA5); send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
    expect_st("after_junk", 1'b0, 1'b1, 1'b0);

    send(8'hA5); send(8'h00); send(8'h01);
    send_byte(8'h5A, 1'b1);
    expect_st("stopbit", 1'b0, 1'b0, 1'b1);

    // A glitch mid-frame must not be consumed as a data byte.
    sb.push_back({11'd0, 16'h5544});
    send(8'hA5); send(8'h00); send(8'h01);
    uart_rx = 1'b0;
    repeat (5) @(posedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    send(8'h44); send(8'h55); send(8'h99);
    expect_st("glitch", 1'b0, 1'b1, 1'b0);

    send(8'hA5); send(8'h00); send(8'h01); send(8'hAA);
    repeat (TMO - 50) @(posedge clk);
    expect_st("tmo_before", 1'b1, 1'b0, 1'b0);
    repeat (25) @(posedge clk);
    expect_st("tmo_after", 1'b0, 1'b0, 1'b1);

    send(8'hA5); send(8'h00); send(8'h01); send(8'h11);
    expect_st("pre_rst", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_loading", 32'(loading), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_wre", 32'(mem_bus.mem_wre), 32'd0);
    send(8'h22);
    rst = 1'b1;
    send(8'h33);
    expect_st("post_rst", 1'b0, 1'b0, 1'b0);

    repeat (4 * CPB) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
